// File: rtl/pipe_fixed_to_float.sv
// Pipelined fixed-point to float converter.
// Normalises with a log-shifter, rounds, then packs/classifies.
module pipe_fixed_to_float #(
  parameter int WII   = 8,
  parameter int WIF   = 8,
  parameter int WOE   = 8,
  parameter int WOM   = 23,
  parameter int ROUND = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic                 i_signed,
  input  logic [WII+WIF-1:0]   in,
  output logic                 o_en,
  output logic [WOE+WOM:0]     out,
  output logic                 o_ovf,
  output logic                 o_unf,
  output logic                 o_inexact
);

  localparam int W    = WII + WIF;
  localparam int NS   = $clog2(W);
  localparam int EW   = WOE + $clog2(W) + 3;
  localparam int BIAS = (1 << (WOE - 1)) - 1;

  localparam logic signed [EW-1:0] EBASE =
    EW'(W - 1 - WIF + BIAS);
  localparam logic signed [EW-1:0] EMAX =
    EW'((1 << WOE) - 1);

  // stage 0 sign/magnitude split
  logic         sgn0;
  logic [W-1:0] mag0;

  assign sgn0 = i_signed & in[W-1];
  assign mag0 = sgn0 ? (~in + W'(1)) : in;

  // pipeline state: index 0 is the input register
  logic [NS+1:0]          vld;
  logic [W-1:0]           mag_q [0:NS];
  logic signed [EW-1:0]   e_q   [0:NS];
  logic [NS:0]            sgn_q;

  logic [W-1:0]           nmag  [1:NS];
  logic signed [EW-1:0]   ne    [1:NS];

  // round stage registers
  logic [WOM-1:0]         r_frac;
  logic signed [EW-1:0]   r_e;
  logic                   r_sgn;
  logic                   r_zero;
  logic                   r_inx;

  // normalise: stage j conditionally shifts by 2^(NS-j)
  always_comb begin
    for (int j = 1; j <= NS; j++) begin
      nmag[j] = mag_q[j-1];
      ne[j]   = e_q[j-1];
      if ((mag_q[j-1] >> (W - (1 << (NS - j)))) == '0) begin
        nmag[j] = mag_q[j-1] << (1 << (NS - j));
        ne[j]   = e_q[j-1] - EW'(1 << (NS - j));
      end
    end
  end

  // round: hidden bit, fraction, guard and sticky
  logic [W+WOM+1:0]     ext;
  logic                 guard;
  logic                 sticky;
  logic                 inc;
  logic [WOM:0]         rsum;
  logic signed [EW-1:0] re;

  always_comb begin
    ext    = {mag_q[NS], {(WOM+2){1'b0}}};
    guard  = ext[W];
    sticky = |ext[W-1:0];
    inc    = (ROUND != 0) && guard && (sticky || ext[W+1]);
    rsum   = {1'b0, ext[W+WOM -: WOM]} + {{WOM{1'b0}}, inc};
    re     = rsum[WOM] ? e_q[NS] + EW'(1) : e_q[NS];
  end

  // valid chain, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) vld <= '0;
    else     vld <= {vld[NS:0], i_en};
  end

  // datapath registers, qualified only by the valid chain
  always_ff @(posedge clk) begin
    mag_q[0] <= mag0;
    e_q[0]   <= EBASE;
    sgn_q[0] <= sgn0;
    for (int j = 1; j <= NS; j++) begin
      mag_q[j] <= nmag[j];
      e_q[j]   <= ne[j];
      sgn_q[j] <= sgn_q[j-1];
    end
    r_frac <= rsum[WOM-1:0];
    r_e    <= re;
    r_sgn  <= sgn_q[NS];
    r_zero <= ~ext[W+WOM+1];
    r_inx  <= guard | sticky;
  end

  // pack and classify; outputs hold when no sample arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      o_en      <= 1'b0;
      out       <= '0;
      o_ovf     <= 1'b0;
      o_unf     <= 1'b0;
      o_inexact <= 1'b0;
    end else begin
      o_en <= vld[NS+1];
      if (vld[NS+1]) begin
        if (r_zero) begin
          out       <= '0;
          o_ovf     <= 1'b0;
          o_unf     <= 1'b0;
          o_inexact <= 1'b0;
        end else if (r_e >= EMAX) begin
          out       <= {r_sgn, {WOE{1'b1}}, {WOM{1'b0}}};
          o_ovf     <= 1'b1;
          o_unf     <= 1'b0;
          o_inexact <= 1'b1;
        end else if (r_e[EW-1] || r_e == '0) begin
          out       <= {r_sgn, {(WOE+WOM){1'b0}}};
          o_ovf     <= 1'b0;
          o_unf     <= 1'b1;
          o_inexact <= 1'b1;
        end else begin
          out       <= {r_sgn, r_e[WOE-1:0], r_frac};
          o_ovf     <= 1'b0;
          o_unf     <= 1'b0;
          o_inexact <= r_inx;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_fixed_to_float.sv
// Bench for pipe_fixed_to_float: four configurations in lockstep
// against an arithmetic reference model.
module tb_pipe_fixed_to_float;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_en = 1'b0;
  logic i_signed = 1'b0;
  logic [15:0] ia = '0;
  logic [31:0] ib = '0;
  logic [23:0] ic = '0;

  logic ea, eb, ec, ed;
  logic [31:0] oa;
  logic [15:0] ob, oc, od;
  logic va, ua, xa, vb, ub, xb, vc, uc, xc, vd, ud, xd;

  always #5 clk = ~clk;

  pipe_fixed_to_float dut_a (
    .clk(clk), .rst(rst), .i_en(i_en), .i_signed(i_signed),
    .in(ia), .o_en(ea), .out(oa),
    .o_ovf(va), .o_unf(ua), .o_inexact(xa));

  pipe_fixed_to_float #(
    .WII(8), .WIF(24), .WOE(5), .WOM(10), .ROUND(1)
  ) dut_b (
    .clk(clk), .rst(rst), .i_en(i_en), .i_signed(i_signed),
    .in(ib), .o_en(eb), .out(ob),
    .o_ovf(vb), .o_unf(ub), .o_inexact(xb));

  pipe_fixed_to_float #(
    .WII(24), .WIF(0), .WOE(5), .WOM(10), .ROUND(1)
  ) dut_c (
    .clk(clk), .rst(rst), .i_en(i_en), .i_signed(i_signed),
    .in(ic), .o_en(ec), .out(oc),
    .o_ovf(vc), .o_unf(uc), .o_inexact(xc));

  pipe_fixed_to_float #(
    .WII(24), .WIF(0), .WOE(5), .WOM(10), .ROUND(0)
  ) dut_d (
    .clk(clk), .rst(rst), .i_en(i_en), .i_signed(i_signed),
    .in(ic), .o_en(ed), .out(od),
    .o_ovf(vd), .o_unf(ud), .o_inexact(xd));

  typedef struct {
    int          arr;
    logic [66:0] v;
  } ex_t;

  ex_t q [4][$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;

  // value-level reference: {bits, ovf, unf, inexact}
  function automatic logic [66:0] model(
    longint unsigned raw, bit sg,
    int wi, int wf, int we, int wm, bit rnd);
    longint unsigned full, m, q1, rem, half, sbit, ebits;
    int w, p, e, bias, emax, sh;
    bit neg, inx;
    w    = wi + wf;
    full = 64'd1 << w;
    raw  = raw & (full - 1);
    neg  = sg && (((raw >> (w - 1)) & 1) == 1);
    m    = neg ? full - raw : raw;
    if (m == 0) return '0;
    p = 0;
    for (int i = 0; i < w; i++)
      if (((m >> i) & 1) == 1) p = i;
    bias = (1 << (we - 1)) - 1;
    emax = (1 << we) - 1;
    e    = p - wf + bias;
    inx  = 1'b0;
    if (p > wm) begin
      sh   = p - wm;
      q1   = m >> sh;
      rem  = m - (q1 << sh);
      half = 64'd1 << (sh - 1);
      inx  = (rem != 0);
      if (rnd && (rem > half || (rem == half && q1[0])))
        q1++;
      if (q1 == (64'd1 << (wm + 1))) begin
        q1 = q1 >> 1;
        e++;
      end
    end else begin
      q1 = m << (wm - p);
    end
    sbit = longint'(neg) << (we + wm);
    if (e >= emax) begin
      ebits = 64'(emax) << wm;
      return {sbit | ebits, 3'b101};
    end
    if (e <= 0) return {sbit, 3'b011};
    ebits = 64'(e) << wm;
    return {sbit | ebits | (q1 - (64'd1 << wm)), 2'b00, inx};
  endfunction

  task automatic chk(int k, string tag, logic en, logic [66:0] obs);
    logic want;
    ex_t  x;
    want = (q[k].size() > 0) && (q[k][0].arr == cyc);
    total++;
    assert (en === want) else begin
      bad++;
      $error("FAIL %s_en cyc=%0d got=%b exp=%b", tag, cyc, en, want);
    end
    if (want) begin
      x = q[k].pop_front();
      if (en === 1'b1) begin
        total++;
        assert (obs === x.v) else begin
          bad++;
          $error("FAIL %s_out cyc=%0d got=%h exp=%h",
                 tag, cyc, obs, x.v);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    chk(0, "a", ea, {32'b0, oa, va, ua, xa});
    chk(1, "b", eb, {48'b0, ob, vb, ub, xb});
    chk(2, "c", ec, {48'b0, oc, vc, uc, xc});
    chk(3, "d", ed, {48'b0, od, vd, ud, xd});
  endtask

  task automatic zchk(string tag);
    total++;
    assert ({ea, oa, va, ua, xa} === '0) else begin
      bad++;
      $error("FAIL %s_a got=%h exp=0", tag, {ea, oa, va, ua, xa});
    end
    total++;
    assert ({eb, ob, vb, ub, xb, ec, oc, vc, uc, xc} === '0) else begin
      bad++;
      $error("FAIL %s_bc got=%h exp=0", tag,
             {eb, ob, vb, ub, xb, ec, oc, vc, uc, xc});
    end
    total++;
    assert ({ed, od, vd, ud, xd} === '0) else begin
      bad++;
      $error("FAIL %s_d got=%h exp=0", tag, {ed, od, vd, ud, xd});
    end
  endtask

  task automatic step(bit en, bit sg, logic [15:0] a,
                      logic [31:0] b, logic [23:0] c);
    i_en     = en;
    i_signed = sg;
    ia       = a;
    ib       = b;
    ic       = c;
    if (rst) begin
      for (int k = 0; k < 4; k++) q[k].delete();
    end else if (en) begin
      q[0].push_back(ex_t'{cyc + 7, model(64'(a), sg, 8, 8, 8, 23, 1)});
      q[1].push_back(ex_t'{cyc + 8, model(64'(b), sg, 8, 24, 5, 10, 1)});
      q[2].push_back(ex_t'{cyc + 8, model(64'(c), sg, 24, 0, 5, 10, 1)});
      q[3].push_back(ex_t'{cyc + 8, model(64'(c), sg, 24, 0, 5, 10, 0)});
    end
    tick();
  endtask

  task automatic rstep();
    logic [31:0] r;
    r = $urandom >> ($urandom % 32);
    step(($urandom % 4) != 0, 1'($urandom), 16'(r ^ $urandom),
         r, 24'($urandom >> ($urandom % 24)));
  endtask

  initial begin
    rst = 1'b1;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    zchk("reset");
    rst = 1'b0;

    step(1, 1, 16'h0100, 32'd1, 24'd65520);
    step(0, 0, 0, 0, 0);
    step(1, 1, 16'hFF00, 32'd1 << 10, 24'd2049);
    step(1, 1, 16'h0001, 32'd0, 24'd0);
    step(0, 0, 0, 0, 0);
    step(1, 1, 16'h8000, 32'h8000_0000, 24'd65535);
    step(1, 0, 16'h8000, 32'h8000_0000, 24'hFF_FFFF);
    step(1, 0, 16'h0000, 32'h0000_0400, 24'd2051);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);

    for (int i = 0; i < 300; i++) rstep();

    for (int i = 0; i < 10; i++) begin
      rst = (i == 4);
      step(1, 1'($urandom), 16'($urandom), $urandom, 24'($urandom));
      if (i == 4) zchk("midrst");
    end
    rst = 1'b0;

    for (int i = 0; i < 200; i++) rstep();
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
